// File: rtl/imem_stall_ctrl_if.sv
// Instruction-memory handshake bundle: requester side (Addr/Rd/Wr -> DataOut/Done/Stall)
// plus the backing-memory req/valid port and the hit/miss statistics.
interface imem_stall_ctrl_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // The responder: the stall controller itself.
    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump, mem_rdata, mem_valid,
        output DataOut, Done, Stall, CacheHit, err,
        output mem_addr, mem_rd, mem_wr, mem_wdata, hit_cnt, miss_cnt
    );

    // The environment: fetch-stage requester together with the backing memory.
    modport master (
        output Addr, DataIn, Rd, Wr, createdump, mem_rdata, mem_valid,
        input  DataOut, Done, Stall, CacheHit, err,
        input  mem_addr, mem_rd, mem_wr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/imem_stall_ctrl.sv
// Fetch-stage instruction-memory responder: direct-mapped, one-word-per-line, write-through cache
// in front of a multi-cycle backing memory, with a bounded wait and saturating hit/miss counters.
module imem_stall_ctrl #(
    parameter int LINES   = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             rst,
    imem_stall_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 15 - IDXW;
    localparam int CNTW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, MISS_REQ, MISS_WAIT, WR_REQ, WR_WAIT, RESP
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       resp_q, resp_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   tmr_q, tmr_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [15:0]       line_data_q [LINES];
    logic [TAGW-1:0]   line_tag_q  [LINES];

    logic              line_we, tag_we;
    logic [IDXW-1:0]   line_idx;
    logic [15:0]       line_wdata;

    logic [IDXW-1:0]   req_idx, lat_idx;
    logic [TAGW-1:0]   req_tag;
    logic              req_hit, req_bad;

    logic [15:0]       data_out, mem_addr, mem_wdata;
    logic              done, stall, cache_hit, err_out, mem_rd, mem_wr;

    assign req_idx = bus.Addr[IDXW:1];
    assign req_tag = bus.Addr[15:IDXW+1];
    assign lat_idx = addr_q[IDXW:1];
    assign req_hit = valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);
    assign req_bad = (bus.Rd && bus.Wr) || (bus.Addr[0] && (bus.Rd || bus.Wr));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        err_d      = err_q;
        tmr_d      = tmr_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = valid_q;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_idx   = lat_idx;
        line_wdata = bus.mem_rdata;
        data_out   = 16'h0000;
        done       = 1'b0;
        stall      = 1'b0;
        cache_hit  = 1'b0;
        err_out    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 16'h0000;
        mem_wdata  = 16'h0000;

        // Reset silences the combinational hit/error paths too, not just the registers.
        if (rst) begin
            unique case (state_q)
                IDLE: begin
                    if (req_bad) begin
                        done    = 1'b1;
                        err_out = 1'b1;
                    end else if (bus.Rd) begin
                        if (req_hit) begin
                            done      = 1'b1;
                            cache_hit = 1'b1;
                            data_out  = line_data_q[req_idx];
                            if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
                        end else begin
                            stall   = 1'b1;
                            addr_d  = bus.Addr;
                            resp_d  = 16'h0000;
                            err_d   = 1'b0;
                            state_d = MISS_REQ;
                            if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end else if (bus.Wr) begin
                        stall   = 1'b1;
                        addr_d  = bus.Addr;
                        wdata_d = bus.DataIn;
                        resp_d  = 16'h0000;
                        err_d   = 1'b0;
                        state_d = WR_REQ;
                        // Write-through without allocation: only a resident line is refreshed.
                        if (req_hit) begin
                            line_we    = 1'b1;
                            line_idx   = req_idx;
                            line_wdata = bus.DataIn;
                        end
                    end
                end
                MISS_REQ: begin
                    stall    = 1'b1;
                    mem_rd   = 1'b1;
                    mem_addr = addr_q;
                    tmr_d    = '0;
                    state_d  = MISS_WAIT;
                end
                MISS_WAIT: begin
                    stall    = 1'b1;
                    mem_addr = addr_q;
                    tmr_d    = tmr_q + 1'b1;
                    if (bus.mem_valid) begin
                        line_we          = 1'b1;
                        tag_we           = 1'b1;
                        valid_d[lat_idx] = 1'b1;
                        resp_d           = bus.mem_rdata;
                        state_d          = RESP;
                    end else if (tmr_q == CNTW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
                WR_REQ: begin
                    stall     = 1'b1;
                    mem_wr    = 1'b1;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    tmr_d     = '0;
                    state_d   = WR_WAIT;
                end
                WR_WAIT: begin
                    stall    = 1'b1;
                    mem_addr = addr_q;
                    tmr_d    = tmr_q + 1'b1;
                    if (bus.mem_valid) begin
                        state_d = RESP;
                    end else if (tmr_q == CNTW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
                RESP: begin
                    done     = 1'b1;
                    err_out  = err_q;
                    data_out = resp_q;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            resp_q     <= 16'h0000;
            err_q      <= 1'b0;
            tmr_q      <= '0;
            hit_cnt_q  <= 16'h0000;
            miss_cnt_q <= 16'h0000;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            tmr_q      <= tmr_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
        end
    end

    // NOTE: line data and tags are not reset; valid_q alone decides whether a line may be used.
    always_ff @(posedge clk) begin
        if (line_we) line_data_q[line_idx] <= line_wdata;
        if (tag_we)  line_tag_q[lat_idx]   <= addr_q[15:IDXW+1];
    end

    assign bus.DataOut   = data_out;
    assign bus.Done      = done;
    assign bus.Stall     = stall;
    assign bus.CacheHit  = cache_hit;
    assign bus.err       = err_out;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_imem_stall_ctrl.sv
// Bench for imem_stall_ctrl: drives requests, plays a latency-3 backing memory, and checks
// responses against expectations queued when each request is issued.
module tb_imem_stall_ctrl;
    typedef struct packed {
        logic        done;
        logic [15:0] data;
        logic        hit;
        logic        err;
    } resp_t;

    logic clk;
    logic rst;
    imem_stall_ctrl_if bus();

    imem_stall_ctrl #(.LINES(8), .TIMEOUT(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    resp_t       sb[$];

    logic [15:0] mm [256];
    int          pend = 0;
    logic [15:0] pend_addr = 16'h0000;
    logic        mute = 1'b0;
    logic        inject = 1'b0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;
    int          rd_cyc = 0;
    logic [15:0] last_waddr = 16'h0000;
    logic [15:0] last_wdata = 16'h0000;

    always @(posedge clk) cyc++;

    // Backing memory: mem_valid is high in the third cycle after the strobe cycle.
    always @(negedge clk) begin
        bus.mem_valid = inject;
        if (inject) bus.mem_rdata = 16'hDEAD;
        if (bus.mem_rd || bus.mem_wr) begin
            pend      = mute ? 0 : 3;
            pend_addr = bus.mem_addr;
            if (bus.mem_rd) begin
                rd_pulses++;
                rd_cyc = cyc;
            end
            if (bus.mem_wr) begin
                wr_pulses++;
                last_waddr = bus.mem_addr;
                last_wdata = bus.mem_wdata;
                mm[bus.mem_addr[7:0]] = bus.mem_wdata;
            end
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.mem_valid = 1'b1;
                bus.mem_rdata = mm[pend_addr[7:0]];
            end
        end
    end

    function automatic resp_t mk(input logic dn, input logic [15:0] dt, input logic h, input logic e);
        resp_t r;
        r.done = dn;
        r.data = dt;
        r.hit  = h;
        r.err  = e;
        return r;
    endfunction

    // Holds the request until Done (bounded), then drops Rd/Wr one cycle later.
    task automatic xfer(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output resp_t obs, output int lat, output logic stall0, output int req_cyc);
        @(negedge clk);
        bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
        req_cyc = cyc;
        #1;
        stall0 = bus.Stall;
        lat = 0;
        while (bus.Done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            #1;
            lat++;
        end
        obs = mk(bus.Done, bus.DataOut, bus.CacheHit, bus.err);
        @(negedge clk);
        bus.Rd = 1'b0; bus.Wr = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0; bus.Rd = 1'b0; bus.Wr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [53:0] outs;
        rst = 1'b0;
        bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 16'h0004; bus.DataIn = 16'h0000;
        repeat (2) @(negedge clk);
        #1;
        outs = {bus.Done, bus.Stall, bus.err, bus.CacheHit, bus.mem_rd, bus.mem_wr,
                bus.DataOut, bus.hit_cnt, bus.miss_cnt};
        n_vec++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        @(negedge clk);
        rst = 1'b1; bus.Rd = 1'b0;
    endtask

    task automatic test_cold_read();
        resp_t obs, exp;
        int lat, rc, rd0;
        logic st;
        rd0 = rd_pulses;
        sb.push_back(mk(1'b1, 16'h1234, 1'b0, 1'b0));
        xfer(1'b1, 1'b0, 16'h0004, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (st !== 1'b1) begin n_err++; $display("FAIL cold_stall got=%b exp=1", st); end
        n_vec++;
        if (obs !== exp) begin n_err++; $display("FAIL cold_resp got=%h exp=%h", obs, exp); end
        n_vec++;
        if (lat != 5) begin n_err++; $display("FAIL cold_latency got=%0d exp=5", lat); end
        n_vec++;
        if (rd_pulses - rd0 != 1 || rd_cyc - rc != 1) begin
            n_err++;
            $display("FAIL cold_mem_rd pulses=%0d offset=%0d exp=1/1", rd_pulses - rd0, rd_cyc - rc);
        end
        n_vec++;
        if (bus.miss_cnt !== 16'd1) begin n_err++; $display("FAIL cold_miss_cnt got=%0d exp=1", bus.miss_cnt); end

        sb.push_back(mk(1'b1, 16'h1234, 1'b1, 1'b0));
        xfer(1'b1, 1'b0, 16'h0004, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 0 || st !== 1'b0) begin
            n_err++;
            $display("FAIL warm_hit got=%h lat=%0d stall=%b exp=%h lat=0 stall=0", obs, lat, st, exp);
        end
        n_vec++;
        if (bus.hit_cnt !== 16'd1) begin n_err++; $display("FAIL hit_cnt got=%0d exp=1", bus.hit_cnt); end
    endtask

    task automatic test_write();
        resp_t obs, exp;
        int lat, rc, wr0;
        logic st;
        wr0 = wr_pulses;
        sb.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b0));
        xfer(1'b0, 1'b1, 16'h0004, 16'hBEEF, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 5 || st !== 1'b1) begin
            n_err++;
            $display("FAIL wr_hit_resp got=%h lat=%0d stall=%b exp=%h lat=5 stall=1", obs, lat, st, exp);
        end
        n_vec++;
        if (wr_pulses - wr0 != 1 || last_wdata !== 16'hBEEF || last_waddr !== 16'h0004) begin
            n_err++;
            $display("FAIL wr_mem_port pulses=%0d addr=%h data=%h exp=1/0004/beef",
                     wr_pulses - wr0, last_waddr, last_wdata);
        end

        // Table: read-after-write hit, write miss, read that must still miss.
        begin
            logic [15:0] t_addr [3] = '{16'h0004, 16'h0006, 16'h0006};
            logic        t_wr   [3] = '{1'b0, 1'b1, 1'b0};
            int          t_lat  [3] = '{0, 5, 5};
            sb.push_back(mk(1'b1, 16'hBEEF, 1'b1, 1'b0));
            sb.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b0));
            sb.push_back(mk(1'b1, 16'h0A0A, 1'b0, 1'b0));
            for (int i = 0; i < 3; i++) begin
                xfer(!t_wr[i], t_wr[i], t_addr[i], 16'h0A0A, obs, lat, st, rc);
                exp = sb.pop_front();
                n_vec++;
                if (obs !== exp || lat != t_lat[i]) begin
                    n_err++;
                    $display("FAIL wr_seq[%0d] got=%h lat=%0d exp=%h lat=%0d", i, obs, lat, exp, t_lat[i]);
                end
            end
        end
        n_vec++;
        if (bus.hit_cnt !== 16'd2 || bus.miss_cnt !== 16'd2) begin
            n_err++;
            $display("FAIL wr_counters hit=%0d miss=%0d exp=2/2", bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    task automatic test_conflict();
        resp_t obs, exp;
        int lat, rc;
        logic st;
        logic [15:0] t_addr [3] = '{16'h0004, 16'h0014, 16'h0004};
        pulse_reset();
        sb.push_back(mk(1'b1, 16'hBEEF, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 16'h5555, 1'b0, 1'b0));
        sb.push_back(mk(1'b1, 16'hBEEF, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, 1'b0, t_addr[i], 16'h0000, obs, lat, st, rc);
            exp = sb.pop_front();
            n_vec++;
            if (obs !== exp || lat != 5) begin
                n_err++;
                $display("FAIL conflict[%0d] got=%h lat=%0d exp=%h lat=5", i, obs, lat, exp);
            end
        end
        n_vec++;
        if (bus.miss_cnt !== 16'd3 || bus.hit_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL conflict_counters miss=%0d hit=%0d exp=3/0", bus.miss_cnt, bus.hit_cnt);
        end
    endtask

    task automatic test_errors();
        resp_t obs, exp;
        int lat, rc, rd0, wr0;
        logic st;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        sb.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b1));
        xfer(1'b1, 1'b0, 16'h0003, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 0) begin
            n_err++;
            $display("FAIL err_misaligned got=%h lat=%0d exp=%h lat=0", obs, lat, exp);
        end
        sb.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b1));
        xfer(1'b1, 1'b1, 16'h0008, 16'h1111, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 0) begin
            n_err++;
            $display("FAIL err_rd_wr got=%h lat=%0d exp=%h lat=0", obs, lat, exp);
        end
        n_vec++;
        if (rd_pulses != rd0 || wr_pulses != wr0) begin
            n_err++;
            $display("FAIL err_no_mem rd=%0d wr=%0d exp=0/0", rd_pulses - rd0, wr_pulses - wr0);
        end

        mute = 1'b1;
        sb.push_back(mk(1'b1, 16'h0000, 1'b0, 1'b1));
        xfer(1'b1, 1'b0, 16'h0008, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 34) begin
            n_err++;
            $display("FAIL timeout got=%h lat=%0d exp=%h lat=34", obs, lat, exp);
        end
        mute = 1'b0;
        sb.push_back(mk(1'b1, 16'h0888, 1'b0, 1'b0));
        xfer(1'b1, 1'b0, 16'h0008, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 5) begin
            n_err++;
            $display("FAIL timeout_no_fill got=%h lat=%0d exp=%h lat=5", obs, lat, exp);
        end
    endtask

    task automatic test_reset_midflight();
        resp_t obs, exp;
        int lat, rc;
        logic st;
        logic [53:0] outs;
        mute = 1'b1;
        @(negedge clk);
        bus.Rd = 1'b1; bus.Wr = 1'b0; bus.Addr = 16'h000A;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (bus.Stall !== 1'b1) begin n_err++; $display("FAIL midflight_stall got=%b exp=1", bus.Stall); end
        rst = 1'b0;
        #1;
        outs = {bus.Done, bus.Stall, bus.err, bus.CacheHit, bus.mem_rd, bus.mem_wr,
                bus.DataOut, bus.hit_cnt, bus.miss_cnt};
        n_vec++;
        if (outs !== '0) begin n_err++; $display("FAIL midflight_reset got=%h exp=0", outs); end
        inject = 1'b1;
        @(negedge clk);
        rst = 1'b1; bus.Rd = 1'b0;
        #1;
        inject = 1'b0;
        @(negedge clk);
        mute = 1'b0;
        sb.push_back(mk(1'b1, 16'h0AAA, 1'b0, 1'b0));
        xfer(1'b1, 1'b0, 16'h000A, 16'h0000, obs, lat, st, rc);
        exp = sb.pop_front();
        n_vec++;
        if (obs !== exp || lat != 5) begin
            n_err++;
            $display("FAIL after_reset_miss got=%h lat=%0d exp=%h lat=5", obs, lat, exp);
        end
        n_vec++;
        if (bus.miss_cnt !== 16'd1 || bus.hit_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL after_reset_counters miss=%0d hit=%0d exp=1/0", bus.miss_cnt, bus.hit_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 16'h0000;
        mm[8'h04] = 16'h1234;
        mm[8'h14] = 16'h5555;
        mm[8'h06] = 16'h0666;
        mm[8'h08] = 16'h0888;
        mm[8'h0A] = 16'h0AAA;
        bus.createdump = 1'b0;
        test_reset();
        test_cold_read();
        test_write();
        test_conflict();
        test_errors();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
